clause_list_reader: RTL and testbench

Read-side walker for the clause table. Given a base index and an entry count, it issues one table read at a time. It then streams the returned clause indices to a downstream consumer, such as the BCP/implication unit, over a valid/ready handshake. It sits between the clause table's read port and the solver datapath, and reports completion and table read errors.

---
 rtl/clause_reader_pkg.sv | 29 ++
 rtl/clause_list_reader.sv | 162 ++++++++++++++++
 tb/tb_clause_list_reader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clause_reader_pkg.sv
// Shared definitions for the clause-table read walker and its consumer.
//   reader_state_t : walker FSM states (IDLE, ISSUE, WAIT, HOLD, DONE)
//   clause_count_t : entry count / remaining counter, TABLE_BITS+1 wide
// Default widths come from CLAUSE_TABLE_BITS and MAX_CLAUSES_BITS. When the
// build does not define them, they are defined here.
`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 4
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

package clause_reader_pkg;

  localparam int DEFAULT_TABLE_BITS  = `CLAUSE_TABLE_BITS;
  localparam int DEFAULT_CLAUSE_BITS = `MAX_CLAUSES_BITS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } reader_state_t;

  // One bit wider than a table index, so a walk can cover the whole table.
  typedef logic [DEFAULT_TABLE_BITS:0] clause_count_t;

endpackage

// File: rtl/clause_list_reader.sv
// clause_list_reader: walks count_in consecutive clause-table entries,
// starting at base_in. It issues one table read at a time and streams each
// returned clause index to a consumer.
//
// Ports:
//   clock, reset            : clock; asynchronous active-low reset
//   start, abort            : begin a walk (sampled in IDLE) / cancel a walk
//   base_in, count_in       : first table index, number of entries (0 legal)
//   table_read, table_index : read strobe and index to the clause table
//   table_clause_in         : table data, valid one cycle after table_read
//   table_error_in          : table error flag, aligned with the data
//   clause_valid, clause_ready, clause_out, clause_last : consumer stream
//   busy, done, err         : not IDLE / one-cycle end pulse / sticky error
//   state_dbg               : current FSM state, for observation
//
// Configuration macro CLAUSE_READER_WRAP_EN:
//   defined   -> ptr wraps modulo 2^TABLE_BITS and the walk continues at 0.
//   undefined -> stepping past the top index with entries still left sets
//                err and ends the walk through DONE.
//
// Handshake: clause_valid is asserted while an entry is presented. The
// transfer happens on a rising edge where clause_valid && clause_ready.
// While clause_valid && !clause_ready, clause_out and clause_last hold steady.
// Valid does not depend on ready.
`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 4
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module clause_list_reader
  import clause_reader_pkg::*;
#(
  parameter int TABLE_BITS  = `CLAUSE_TABLE_BITS,
  parameter int CLAUSE_BITS = `MAX_CLAUSES_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [TABLE_BITS-1:0]  base_in,
  input  logic [TABLE_BITS:0]    count_in,
  output logic                   table_read,
  output logic [TABLE_BITS-1:0]  table_index,
  input  logic [CLAUSE_BITS-1:0] table_clause_in,
  input  logic                   table_error_in,
  output logic                   clause_valid,
  input  logic                   clause_ready,
  output logic [CLAUSE_BITS-1:0] clause_out,
  output logic                   clause_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             state_dbg
);

  reader_state_t          state;
  reader_state_t          state_next;
  logic [TABLE_BITS-1:0]  ptr;
  logic [TABLE_BITS:0]    remaining;
  logic [CLAUSE_BITS-1:0] clause_q;
  logic                   err_q;

  logic accept_start;
  logic last_entry;
  logic handshake;
  logic at_top;

  assign accept_start = (state == IDLE) && start && !abort;
  assign last_entry   = (remaining == {{TABLE_BITS{1'b0}}, 1'b1});
  assign handshake    = (state == HOLD) && clause_ready && !abort;

  // at_top flags a walk that would step past the last table index. With
  // wrapping enabled, that step is legal and ptr simply rolls over to 0.
`ifdef CLAUSE_READER_WRAP_EN
  assign at_top = 1'b0;
`else
  assign at_top = (ptr == {TABLE_BITS{1'b1}});
`endif

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_start) begin
          state_next = (count_in == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT:  state_next = table_error_in ? DONE : HOLD;
      HOLD: begin
        if (clause_ready) begin
          state_next = (last_entry || at_top) ? DONE : ISSUE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // abort overrides everything outside IDLE. There is no done pulse, and
    // any data in flight is dropped.
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      remaining <= '0;
      clause_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept_start) begin
        ptr       <= base_in;
        remaining <= count_in;
        err_q     <= 1'b0;
      end
      if ((state == WAIT) && !abort) begin
        if (table_error_in) begin
          err_q <= 1'b1;
        end else begin
          clause_q <= table_clause_in;
        end
      end
      if (handshake) begin
        if (remaining != '0) begin
          remaining <= remaining - {{TABLE_BITS{1'b0}}, 1'b1};
        end
        ptr <= ptr + {{(TABLE_BITS-1){1'b0}}, 1'b1};
        // Entries already delivered stand; only the walk is cut short.
        if (!last_entry && at_top) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    table_read   = (state == ISSUE);
    table_index  = ptr;
    clause_valid = (state == HOLD);
    clause_out   = clause_q;
    clause_last  = (state == HOLD) && last_entry;
    busy         = (state != IDLE);
    done         = (state == DONE);
    err          = err_q;
    state_dbg    = state;
  end

endmodule

// File: tb/tb_clause_list_reader.sv
// Self-checking bench for clause_list_reader. A behavioural table memory
// answers reads. For each walk, a reference model lists the clauses that
// should be delivered, whether err should end up set, and how many reads
// should be issued. A negedge monitor pops an expected queue on every
// handshake and checks that the output stays stable under backpressure.
module tb_clause_list_reader;

  localparam int TB    = 4;
  localparam int CB    = 8;
  localparam int DEPTH = 1 << TB;

  logic          clock;
  logic          reset;
  logic          start;
  logic          abort;
  logic [TB-1:0] base_in;
  logic [TB:0]   count_in;
  logic          table_read;
  logic [TB-1:0] table_index;
  logic [CB-1:0] table_clause_in = '0;
  logic          table_error_in  = 1'b0;
  logic          clause_valid;
  logic          clause_ready;
  logic [CB-1:0] clause_out;
  logic          clause_last;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    state_dbg;

  clause_list_reader #(.TABLE_BITS(TB), .CLAUSE_BITS(CB)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .base_in         (base_in),
    .count_in        (count_in),
    .table_read      (table_read),
    .table_index     (table_index),
    .table_clause_in (table_clause_in),
    .table_error_in  (table_error_in),
    .clause_valid    (clause_valid),
    .clause_ready    (clause_ready),
    .clause_out      (clause_out),
    .clause_last     (clause_last),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- table memory model ----------------
  logic [CB-1:0] mem [DEPTH];
  logic          err_mem [DEPTH];

  // Data returns one cycle after the read. Between reads, the bus carries
  // noise so that sampling in the wrong cycle shows up.
  always @(posedge clock) begin
    if (table_read) begin
      table_clause_in <= mem[table_index];
      table_error_in  <= err_mem[table_index];
    end else begin
      table_clause_in <= CB'($urandom_range(255));
      table_error_in  <= 1'($urandom_range(1));
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [CB:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int read_cnt, done_cnt, first_read, first_valid;
  logic          prev_hold = 1'b0;
  logic [CB-1:0] prev_out;
  logic          prev_last;

  always @(negedge clock) begin
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      if (table_read) begin
        read_cnt++;
        if (first_read < 0) first_read = cyc;
      end
      if (done) done_cnt++;
      if (clause_valid && first_valid < 0) first_valid = cyc;
      if (prev_hold) begin
        check_eq("stall_valid", clause_valid, 1);
        check_eq("stall_out", clause_out, prev_out);
        check_eq("stall_last", clause_last, prev_last);
      end
      if (clause_valid && clause_ready && !abort) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_clause", 1, 0);
        end else begin
          check_eq("clause", {clause_last, clause_out}, exp_q.pop_front());
        end
      end
      prev_hold = clause_valid && !clause_ready && !abort;
      prev_out  = clause_out;
      prev_last = clause_last;
    end
  end

  // ---------------- driver ----------------
  int acc_cyc;

  // Runs one walk against the reference model. hold = number of valid cycles
  // during which ready is held low on the first entry. noise = throw spurious
  // starts with changing base/count at the busy block.
  task automatic run_walk(input int base, input int cnt, input int rdy_pct,
                          input int hold, input bit noise, output int busy_cycles);
    logic exp_err;
    int   exp_reads;
    int   idx;
    exp_err   = 1'b0;
    exp_reads = 0;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      idx = base + i;
`ifdef CLAUSE_READER_WRAP_EN
      idx = idx % DEPTH;
`else
      if (idx >= DEPTH) begin
        exp_err = 1'b1;
        break;
      end
`endif
      exp_reads++;
      if (err_mem[idx]) begin
        exp_err = 1'b1;
        break;
      end
      exp_q.push_back({(i == cnt - 1), mem[idx]});
    end
    read_cnt = 0; done_cnt = 0; first_read = -1; first_valid = -1;
    base_in  = TB'(base);
    count_in = (TB+1)'(cnt);
    start    = 1'b1;
    clause_ready = 1'b0;
    @(posedge clock); #1;
    start   = 1'b0;
    acc_cyc = cyc;
    check_eq("err_clear", err, 0);
    busy_cycles = 0;
    while (busy && busy_cycles < 300) begin
      if (clause_valid && hold > 0) begin
        check_eq("bp_out", clause_out, mem[base]);
        check_eq("bp_reads", read_cnt, 1);
        clause_ready = 1'b0;
        hold--;
      end else begin
        clause_ready = ($urandom_range(99) < rdy_pct);
      end
      if (noise) begin
        start    = ($urandom_range(3) == 0);
        base_in  = TB'($urandom_range(DEPTH - 1));
        count_in = (TB+1)'($urandom_range(2 * DEPTH - 1));
      end
      @(posedge clock); #1;
      busy_cycles++;
    end
    start = 1'b0;
    clause_ready = 1'b0;
    check_eq("walk_timeout", busy, 0);
    check_eq("err", err, exp_err);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("reads", read_cnt, exp_reads);
    check_eq("left_over", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    int wait_cyc;
    reset = 1'b0; start = 1'b0; abort = 1'b0; clause_ready = 1'b0;
    base_in = '0; count_in = '0;
    read_cnt = 0; done_cnt = 0; first_read = -1; first_valid = -1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = CB'(8'h40 + i);
      err_mem[i] = 1'b0;
    end
    mem[2] = 8'd7; mem[3] = 8'd9; mem[4] = 8'd11;
    mem[15] = 8'h5a; mem[0] = 8'h33;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_read", table_read, 0);
    check_eq("rst_valid", clause_valid, 0);
    check_eq("rst_last", clause_last, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_index", table_index, 0);
    check_eq("rst_out", clause_out, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic walk 7, 9, 11 with ready held high
    run_walk(2, 3, 100, 0, 1'b0, bc);
    check_eq("basic_cycles", bc, 10);
    check_eq("basic_read_lat", first_read - acc_cyc, 0);
    check_eq("basic_valid_lat", first_valid - acc_cyc, 2);

    // Zero-count walk: done right away, no reads
    run_walk(5, 0, 100, 0, 1'b0, bc);
    check_eq("zero_busy", bc, 1);

    // Backpressure on the first entry
    run_walk(2, 2, 100, 4, 1'b0, bc);

    // Table error on the second read
    err_mem[3] = 1'b1;
    run_walk(2, 3, 100, 0, 1'b0, bc);
    repeat (3) @(posedge clock);
    #1;
    check_eq("err_sticky", err, 1);
    err_mem[3] = 1'b0;
    run_walk(3, 1, 100, 0, 1'b0, bc);

    // start with abort in IDLE is ignored
    read_cnt = 0;
    base_in = 4'd2; count_in = 5'd1; start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", busy, 0);
    @(posedge clock); #1;
    check_eq("start_abort_reads", read_cnt, 0);

    // abort while in WAIT
    exp_q.delete();
    done_cnt = 0; first_valid = -1;
    base_in = 4'd2; count_in = 5'd3; start = 1'b1;
    @(posedge clock); #1;                // ISSUE
    start = 1'b0;
    @(posedge clock); #1;                // WAIT
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valid", clause_valid, 0);
    @(posedge clock); #1;
    check_eq("abort_done", done_cnt, 0);
    check_eq("abort_no_valid", first_valid, 32'hffff_ffff);
    run_walk(4, 1, 100, 0, 1'b0, bc);

    // Walk across the top of the table
    run_walk(15, 2, 100, 0, 1'b0, bc);

    // Randomised walks
    for (int w = 0; w < 40; w++) begin
      if (w % 8 == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i]     = CB'($urandom_range(255));
          err_mem[i] = ($urandom_range(19) == 0);
        end
      end
      run_walk($urandom_range(DEPTH - 1), $urandom_range(6),
               $urandom_range(100, 30), 0, 1'b1, bc);
    end

    // Reset asserted mid-HOLD
    for (int i = 0; i < DEPTH; i++) err_mem[i] = 1'b0;
    mem[3] = 8'd9;
    exp_q.delete();
    clause_ready = 1'b0;
    base_in = 4'd3; count_in = 5'd1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_cyc = 0;
    while (!clause_valid && wait_cyc < 10) begin
      @(posedge clock); #1;
      wait_cyc++;
    end
    check_eq("hold_reached", clause_valid, 1);
    check_eq("hold_last", clause_last, 1);
    check_eq("hold_out", clause_out, 9);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_valid", clause_valid, 0);
    check_eq("mid_rst_last", clause_last, 0);
    check_eq("mid_rst_out", clause_out, 0);
    check_eq("mid_rst_index", table_index, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_read", table_read, 0);
    check_eq("mid_rst_err", err, 0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    run_walk(2, 3, 100, 0, 1'b0, bc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
